// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared constants and types for the frequency-meter blocks.
//   DIGITS_DEFAULT : default number of BCD decades in the measurement counter
//   BCD_W          : bits per BCD decade
//   DIGITS_MAX     : widest counter any block in the meter supports
//   ALL_NINES      : all-nines BCD word at DIGITS_MAX width; narrower users slice it
package freq_meter_pkg;

    localparam int unsigned DIGITS_DEFAULT = 6;
    localparam int unsigned BCD_W          = 4;
    localparam int unsigned DIGITS_MAX     = 8;

    localparam logic [BCD_W*DIGITS_MAX-1:0] ALL_NINES = 32'h9999_9999;

    typedef logic [BCD_W-1:0] bcd_t;

endpackage : freq_meter_pkg

// File: rtl/bcd_digit.sv
// bcd_digit: one decade (0..9) of the cascaded measurement counter.
// Ports:
//   clk        : system clock
//   nRST       : asynchronous active-low reset
//   clear      : synchronous clear, wins over inc
//   inc        : advance this decade by one this cycle
//   value      : current decade value (registered)
//   carry_out  : combinational carry into the next decade, inc & (value == 9)
module bcd_digit
    import freq_meter_pkg::*;
(
    input  logic        clk,
    input  logic        nRST,
    input  logic        clear,
    input  logic        inc,
    output bcd_t        value,
    output logic        carry_out
);

    localparam bcd_t NINE = ALL_NINES[BCD_W-1:0];

    logic at_nine_c;

    // The carry is combinational so the whole cascade settles in one cycle.
    assign at_nine_c = (value == NINE);
    assign carry_out = inc & at_nine_c;

    // Decade register: clear has priority, then wrap 9 -> 0 or increment.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc) begin
            value <= at_nine_c ? '0 : value + BCD_W'(1);
        end
    end

endmodule : bcd_digit

// File: rtl/gated_bcd_counter.sv
// gated_bcd_counter: counts rising edges of the asynchronous signal CPx in a
// cascaded BCD counter while gated, latches the count on a store strobe and
// reports overflow and the leading-zero mask of the latched value.
// Parameters:
//   DIGITS      : number of BCD decades (2..8)
//   SYNC_STAGES : CPx synchronizer depth (>= 2)
// Ports:
//   CLK_50   : system clock
//   nRST     : asynchronous active-low reset
//   CPx      : measured signal, asynchronous to CLK_50
//   C_Enable : count gate (level)
//   C_Clear  : counter and overflow clear (level), wins over counting
//   C_Store  : latch request, acted on its rising edge
//   BCD_out  : latched count, digit 0 in bits [3:0]
//   OF       : sticky overflow of the live counter
//   unable   : unable[k] = 1 when latched digits k+1..DIGITS-1 are all zero
//   Valid    : one-cycle pulse the cycle after BCD_out updates
module gated_bcd_counter
    import freq_meter_pkg::*;
#(
    parameter int unsigned DIGITS      = DIGITS_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    CLK_50,
    input  logic                    nRST,
    input  logic                    CPx,
    input  logic                    C_Enable,
    input  logic                    C_Clear,
    input  logic                    C_Store,
    output logic [BCD_W*DIGITS-1:0] BCD_out,
    output logic                    OF,
    output logic [DIGITS-2:0]       unable,
    output logic                    Valid
);

    localparam int unsigned W = BCD_W * DIGITS;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_vld_q;
    logic                   edge_q;
    logic                   store_q;
    logic                   latched_q;

    logic                   count_en_c;
    logic                   store_rise_c;
    logic                   wrap_c;
    logic [W-1:0]           live_c;
    logic [DIGITS-2:0]      unable_nxt_c;
    logic                   upper_zero_c;

    // CPx synchronizer and rising-edge detect. The last synchronizer stage
    // doubles as the edge-detect history, which keeps the CPx-to-count
    // latency at two cycles after the first high sample. sync_vld_q blocks
    // edges until the history stage holds a real post-reset sample, so a CPx
    // that is already high at reset release is not taken for an edge.
    always_ff @(posedge CLK_50 or negedge nRST) begin
        if (!nRST) begin
            sync_q     <= '0;
            sync_vld_q <= '0;
            edge_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], CPx};
            sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
            edge_q     <= sync_vld_q[SYNC_STAGES-1]
                        & sync_q[SYNC_STAGES-2]
                        & ~sync_q[SYNC_STAGES-1];
        end
    end

    // Cycle-exact gate: an event is dropped unless enabled in its own cycle.
    assign count_en_c = edge_q & C_Enable & ~C_Clear;

    // Decade cascade; each stage's increment is the previous stage's carry.
    for (genvar k = 0; k < int'(DIGITS); k++) begin : g_digit
        logic inc_k;
        logic carry_k;

        if (k == 0) begin : g_first
            assign inc_k = count_en_c;
        end else begin : g_next
            assign inc_k = g_digit[k-1].carry_k;
        end

        bcd_digit u_digit (
            .clk       (CLK_50),
            .nRST      (nRST),
            .clear     (C_Clear),
            .inc       (inc_k),
            .value     (live_c[BCD_W*k +: BCD_W]),
            .carry_out (carry_k)
        );
    end

    // A carry out of the top decade means the counter wrapped past all nines.
    assign wrap_c = g_digit[DIGITS-1].carry_k;

    // Sticky overflow, cleared only by C_Clear.
    always_ff @(posedge CLK_50 or negedge nRST) begin
        if (!nRST) begin
            OF <= 1'b0;
        end else if (C_Clear) begin
            OF <= 1'b0;
        end else if (wrap_c) begin
            OF <= 1'b1;
        end
    end

    // Leading-zero mask of the live value, scanned from the top decade down.
    always_comb begin
        unable_nxt_c = '0;
        upper_zero_c = 1'b1;
        for (int k = int'(DIGITS) - 2; k >= 0; k--) begin
            upper_zero_c    = upper_zero_c & (live_c[BCD_W*(k+1) +: BCD_W] == '0);
            unable_nxt_c[k] = upper_zero_c;
        end
    end

    // Store strobe is acted on its rising edge only.
    assign store_rise_c = C_Store & ~store_q;

    // Output latch. It samples the pre-update live value, so a coincident
    // count or clear lands in the counter but not in this latch.
    always_ff @(posedge CLK_50 or negedge nRST) begin
        if (!nRST) begin
            store_q   <= 1'b0;
            latched_q <= 1'b0;
            Valid     <= 1'b0;
            BCD_out   <= '0;
            unable    <= '1;
        end else begin
            store_q   <= C_Store;
            latched_q <= store_rise_c;
            Valid     <= latched_q;
            if (store_rise_c) begin
                BCD_out <= live_c;
                unable  <= unable_nxt_c;
            end
        end
    end

endmodule : gated_bcd_counter

// File: tb/tb_gated_bcd_counter.sv
// Scoreboard bench for gated_bcd_counter: a six-decade instance (a) for the
// main function and a two-decade instance (b) that reaches wrap-around quickly.
module tb_gated_bcd_counter;
    import freq_meter_pkg::*;

    logic clk = 1'b0;
    logic nrst = 1'b0;

    logic cpx_a = 1'b0, en_a = 1'b0, clr_a = 1'b0, st_a = 1'b0;
    logic cpx_b = 1'b0, en_b = 1'b0, clr_b = 1'b0, st_b = 1'b0;

    logic [23:0] bcd_a;
    logic        of_a;
    logic [4:0]  unable_a;
    logic        valid_a;

    logic [7:0]  bcd_b;
    logic        of_b;
    logic [0:0]  unable_b;
    logic        valid_b;

    always #10 clk = ~clk;

    gated_bcd_counter #(.DIGITS(6), .SYNC_STAGES(2)) u_dut_a (
        .CLK_50   (clk),
        .nRST     (nrst),
        .CPx      (cpx_a),
        .C_Enable (en_a),
        .C_Clear  (clr_a),
        .C_Store  (st_a),
        .BCD_out  (bcd_a),
        .OF       (of_a),
        .unable   (unable_a),
        .Valid    (valid_a)
    );

    gated_bcd_counter #(.DIGITS(2), .SYNC_STAGES(2)) u_dut_b (
        .CLK_50   (clk),
        .nRST     (nrst),
        .CPx      (cpx_b),
        .C_Enable (en_b),
        .C_Clear  (clr_b),
        .C_Store  (st_b),
        .BCD_out  (bcd_b),
        .OF       (of_b),
        .unable   (unable_b),
        .Valid    (valid_b)
    );

    typedef struct {
        int          inst;
        logic [23:0] bcd;
        logic [4:0]  unable;
        logic        of;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_store  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic expect_store(input int inst, input logic [23:0] bcd,
                                input logic [4:0] un, input logic of);
        exp_t e;
        e.inst   = inst;
        e.bcd    = bcd;
        e.unable = un;
        e.of     = of;
        e.id     = n_store;
        n_store++;
        exp_q.push_back(e);
    endtask

    // Monitor: every Valid pulse pops one expected latch result.
    task automatic score(input int inst, input logic [23:0] bcd,
                         input logic [4:0] un, input logic of);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_valid: inst %0d bcd %h unable %b OF %b, expected no Valid",
                     inst, bcd, un, of);
        end else begin
            e = exp_q.pop_front();
            if (e.inst == inst && e.bcd === bcd && e.unable === un && e.of === of)
                n_pass++;
            else
                $display("FAIL store%0d: inst %0d bcd %h unable %b OF %b, expected inst %0d bcd %h unable %b OF %b",
                         e.id, inst, bcd, un, of, e.inst, e.bcd, e.unable, e.of);
        end
    endtask

    always @(negedge clk) begin
        if (nrst && valid_a) score(0, bcd_a, unable_a, of_a);
        if (nrst && valid_b) score(1, {16'h0, bcd_b}, {4'h0, unable_b}, of_b);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulses_a(input int n, input int half);
        for (int i = 0; i < n; i++) begin
            cpx_a = 1'b1;
            repeat (half) tick();
            cpx_a = 1'b0;
            repeat (half) tick();
        end
    endtask

    task automatic pulses_b(input int n, input int half);
        for (int i = 0; i < n; i++) begin
            cpx_b = 1'b1;
            repeat (half) tick();
            cpx_b = 1'b0;
            repeat (half) tick();
        end
    endtask

    // Store strobe on a: latch visible after edge m, Valid high after m+1.
    task automatic store_a(input logic [23:0] bcd, input logic [4:0] un, input logic of);
        expect_store(0, bcd, un, of);
        st_a = 1'b1;
        tick();
        st_a = 1'b0;
        @(negedge clk);
        check("latch_a", 32'(bcd_a), 32'(bcd));
        check("valid_a_early", 32'(valid_a), 32'd0);
        @(negedge clk);
        check("valid_a_timing", 32'(valid_a), 32'd1);
    endtask

    task automatic store_b(input logic [7:0] bcd, input logic un, input logic of);
        expect_store(1, {16'h0, bcd}, {4'h0, un}, of);
        st_b = 1'b1;
        tick();
        st_b = 1'b0;
        @(negedge clk);
        check("latch_b", 32'(bcd_b), 32'(bcd));
        @(negedge clk);
        check("valid_b_timing", 32'(valid_b), 32'd1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_bcd_a", 32'(bcd_a), 32'd0);
        check("rst_unable_a", 32'(unable_a), 32'h1F);
        check("rst_of_a", 32'(of_a), 32'd0);
        check("rst_valid_a", 32'(valid_a), 32'd0);
        check("rst_unable_b", 32'(unable_b), 32'd1);
        nrst = 1'b1;
        repeat (4) tick();

        // Gated count of 1234 periods of 8 cycles
        en_a = 1'b1;
        pulses_a(1234, 4);
        repeat (4) tick();
        en_a = 1'b0;
        tick();
        store_a(24'h001234, 5'b11000, 1'b0);
        repeat (3) tick();

        // Events with the gate closed are discarded
        pulses_a(5, 4);
        repeat (4) tick();
        store_a(24'h001234, 5'b11000, 1'b0);
        repeat (3) tick();

        // Clear
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        tick();
        store_a(24'h000000, 5'h1F, 1'b0);
        repeat (3) tick();

        // Gate falls as the edge-detect register goes high: not counted
        en_a = 1'b1;
        cpx_a = 1'b1;
        tick();
        tick();
        en_a = 1'b0;
        repeat (4) tick();
        cpx_a = 1'b0;
        repeat (4) tick();
        store_a(24'h000000, 5'h1F, 1'b0);
        repeat (3) tick();

        // Gate falls one cycle later: counted
        en_a = 1'b1;
        cpx_a = 1'b1;
        tick();
        tick();
        tick();
        en_a = 1'b0;
        repeat (3) tick();
        cpx_a = 1'b0;
        repeat (4) tick();
        store_a(24'h000001, 5'h1F, 1'b0);
        repeat (3) tick();

        // Store coincident with a count event: latch 1, counter 2
        en_a = 1'b1;
        cpx_a = 1'b1;
        tick();
        tick();
        store_a(24'h000001, 5'h1F, 1'b0);
        cpx_a = 1'b0;
        en_a = 1'b0;
        repeat (4) tick();
        store_a(24'h000002, 5'h1F, 1'b0);
        repeat (3) tick();

        // Store held 10 cycles with clear rising on the same edge
        expect_store(0, 24'h000002, 5'h1F, 1'b0);
        st_a = 1'b1;
        clr_a = 1'b1;
        tick();
        tick();
        clr_a = 1'b0;
        repeat (8) tick();
        st_a = 1'b0;
        repeat (3) tick();
        store_a(24'h000000, 5'h1F, 1'b0);
        repeat (3) tick();

        // Wrap on the two-decade instance: 98 + 3 -> 01 with OF
        en_b = 1'b1;
        pulses_b(98, 2);
        repeat (4) tick();
        store_b(8'h98, 1'b0, 1'b0);
        repeat (3) tick();
        pulses_b(3, 2);
        repeat (4) tick();
        store_b(8'h01, 1'b1, 1'b1);
        repeat (3) tick();
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        @(negedge clk);
        check("of_b_after_clear", 32'(of_b), 32'd0);
        store_b(8'h00, 1'b1, 1'b0);
        repeat (3) tick();

        // Drive b into overflow again and load a nonzero latch on a
        pulses_b(100, 2);
        repeat (4) tick();
        store_b(8'h00, 1'b1, 1'b1);
        repeat (3) tick();
        en_a = 1'b1;
        pulses_a(12, 2);
        repeat (4) tick();
        store_a(24'h000012, 5'b11110, 1'b0);
        repeat (3) tick();

        // Reset mid-count with CPx high, held high across release
        pulses_a(3, 2);
        cpx_a = 1'b1;
        cpx_b = 1'b1;
        tick();
        #5;
        nrst = 1'b0;
        #1;
        check("midrst_bcd_a", 32'(bcd_a), 32'd0);
        check("midrst_unable_a", 32'(unable_a), 32'h1F);
        check("midrst_valid_a", 32'(valid_a), 32'd0);
        check("midrst_of_b", 32'(of_b), 32'd0);
        check("midrst_bcd_b", 32'(bcd_b), 32'd0);
        repeat (2) tick();
        nrst = 1'b1;
        repeat (10) tick();
        cpx_a = 1'b0;
        cpx_b = 1'b0;
        repeat (4) tick();
        store_a(24'h000000, 5'h1F, 1'b0);
        repeat (3) tick();
        store_b(8'h00, 1'b1, 1'b0);
        repeat (3) tick();
        en_b = 1'b0;

        // Throughput at the maximum CPx rate: 10000 periods of 4 cycles
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        en_a = 1'b1;
        pulses_a(10000, 2);
        en_a = 1'b0;
        repeat (4) tick();
        store_a(24'h010000, 5'b10000, 1'b0);
        repeat (4) tick();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_gated_bcd_counter

// File: doc/gated_bcd_counter.md
# gated_bcd_counter

Measurement-side counterpart of the frequency-meter control block: it consumes the C_Clear / C_Enable / C_Store control strobes and the unknown signal CPx. It counts CPx rising edges in a cascaded BCD counter while enabled, latches the result on store, and returns the overflow flag OF and the leading-zero mask `unable` to the control block for auto-ranging and display blanking. It sits between the input conditioning and the display driver.

## Interface
Parameters:
- DIGITS, 6, number of BCD decades, 2..8
- SYNC_STAGES, 2, CPx synchronizer depth, at least 2

Ports:
- CLK_50  input  1  system clock, 50 MHz
- nRST  input  1  asynchronous, active-low reset
- CPx  input  1  measured signal, asynchronous to CLK_50
- C_Enable  input  1  count gate, level, CLK_50-synchronous
- C_Clear  input  1  counter clear, level, CLK_50-synchronous
- C_Store  input  1  latch request, acted on its rising edge, CLK_50-synchronous
- BCD_out  output  4*DIGITS  latched count, digit 0 in bits [3:0]
- OF  output  1  sticky overflow of the live counter
- unable  output  DIGITS-1  leading-zero mask of the latched value
- Valid  output  1  one-cycle pulse, the cycle after the latch updates

## Operation
- CPx passes through a SYNC_STAGES flip-flop chain, then a registered rising-edge detector. A detected edge is a count event.
- A count event increments the live counter only when C_Enable=1 and C_Clear=0. Events arriving while C_Enable=0 are discarded, not deferred.
- Each decade counts 0..9. Carry ripples to the next decade combinationally, so the whole counter updates in the same cycle.
- Wrap-around: a count event with all decades at 9 sets every decade to 0 and sets OF=1. OF stays set until a clear. Further events keep counting normally.
- C_Clear=1 sets every decade to 0 and OF to 0 on every cycle it is held. It has priority over counting.
- Rising edge of C_Store (C_Store=1 this cycle, 0 in the previous cycle): BCD_out takes the live counter value, then Valid pulses in the next cycle. Holding C_Store high does not re-latch.
- Store and count event in the same cycle: the latch takes the pre-increment value, and the counter still increments.
- Store and clear in the same cycle: the latch takes the pre-clear value, and the counter clears.
- unable[k]=1 when latched digits k+1 through DIGITS-1 are all 0. Its value is registered and updates in the same cycle as BCD_out.
- Reset mid-operation: all state returns to the reset values immediately. Synchronizer contents are discarded, so no spurious edge is counted after nRST is released.

## Timing
- Reset values: BCD_out=0, OF=0, Valid=0, unable = all ones, live counter=0, synchronizer and edge registers=0.
- CPx latency (SYNC_STAGES=2): if CPx is first sampled high at clock edge n, the counter shows the increment after edge n+2.
- CPx constraints: high and low phases of at least 2 CLK_50 periods, so at most 12.5 MHz. Violations may lose counts, but never double-count.
- C_Store rise sampled at edge m: BCD_out and unable are valid after edge m, and Valid is high between edges m+1 and m+2.
- C_Clear sampled at edge m: the counter reads 0 after edge m.
- The gate is cycle-exact: an event is counted only if C_Enable=1 in the same cycle the edge-detect register is high.

## Structure
- Shared package freq_meter_pkg holds:
  - DIGITS_DEFAULT = 6
  - BCD_W = 4
  - the all-nines constant
- Sub-module bcd_digit, instantiated DIGITS times through generate:
  - inputs: clk, nRST, clear, inc
  - outputs: 4-bit value, carry_out = inc & (value==9)
- Top level holds the synchronizer, edge detect, store-edge detect, latch, OF and the unable logic.

## Test plan
- Reset: assert nRST=0 mid-count. Required: BCD_out=0, unable=all ones, OF=0 within the same cycle. After release, CPx already high produces no count.
- Gated count: C_Enable=1 for 1234 CPx periods of 8 cycles each, then C_Enable=0, then C_Store pulse. Required: BCD_out=0x001234, unable=5'b11000, and Valid one cycle after the latch.
- Wrap: start from a count of 999998, apply 3 enabled edges, then store. Required: BCD_out=0x000001 and OF=1. After C_Clear, OF=0.
- Gate boundary: a CPx edge lands in the cycle C_Enable falls. Required: counted only if C_Enable=1 in the edge-detect cycle, checked both ways. Also cover a simultaneous store and count event: latch holds N, counter holds N+1.
- Store with clear and hold: C_Store held high for 10 cycles while C_Clear rises on the same edge. Required: a single latch of the pre-clear value and a single Valid pulse.
- Throughput: CPx at 12.5 MHz for 100000 cycles enabled. Required: count equals 25000 exactly, with no loss or double-count.
